// File: rtl/genram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : genram_sdp
// Description : Simple-dual-port RAM with per-lane write mask, selectable
//               read-during-write behaviour, optional output register and a
//               clear engine that fills the array after reset or on request.
// Revision    : 1.0 - initial release
// ============================================================================
module genram_sdp #(
    parameter int             AW       = 9,
    parameter int             DW       = 12,
    parameter int             LW       = 4,
    parameter int             OREG     = 0,
    parameter int             RDW_MODE = 0,
    parameter logic [DW-1:0]  CLR_VAL  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [DW/LW-1:0]     wmask,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    output logic [DW-1:0]        data_out,
    output logic                 rvalid,
    input  logic                 clr,
    output logic                 busy
);

    localparam int c_NPOS = 2**AW;
    localparam int c_NL   = DW / LW;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [AW-1:0]       r_cptr_q,  w_cptr_d;
    logic [DW-1:0]       r_mem_q [c_NPOS];

    logic                w_ready;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [c_NL-1:0]     w_lane_en;
    logic [AW-1:0]       w_mem_addr;
    logic [DW-1:0]       w_mem_wdata;
    logic [DW-1:0]       w_rd_old;
    logic [DW-1:0]       w_rd_merged;
    logic [DW-1:0]       w_rd_word;

    logic [DW-1:0]       r_dout_q;
    logic                r_rvalid_q;

    always_comb begin
        w_ready   = (r_state_q == ST_READY);
        w_rd_acc  = w_ready & re;
        // A write coinciding with a clear request is dropped.
        w_wr_acc  = w_ready & we & ~clr;

        w_state_d = r_state_q;
        w_cptr_d  = r_cptr_q;
        case (r_state_q)
            ST_CLEAR: begin
                w_cptr_d = r_cptr_q + AW'(1);
                if (&r_cptr_q) begin
                    w_state_d = ST_READY;
                end
            end
            default: begin
                if (clr) begin
                    w_state_d = ST_CLEAR;
                    w_cptr_d  = '0;
                end
            end
        endcase

        w_lane_en   = w_ready ? (w_wr_acc ? wmask : '0) : '1;
        w_mem_addr  = w_ready ? waddr : r_cptr_q;
        w_mem_wdata = w_ready ? wdata : CLR_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_CLEAR;
            r_cptr_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cptr_q  <= w_cptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int l = 0; l < c_NL; l++) begin
                if (w_lane_en[l]) begin
                    r_mem_q[w_mem_addr][l*LW +: LW] <= w_mem_wdata[l*LW +: LW];
                end
            end
        end
    end

    // Write-first view of the read address: new lanes where this cycle writes them.
    assign w_rd_old = r_mem_q[raddr];

    genvar gl;
    generate
        for (gl = 0; gl < c_NL; gl++) begin : g_lane
            assign w_rd_merged[gl*LW +: LW] =
                (w_wr_acc && (waddr == raddr) && wmask[gl]) ? wdata[gl*LW +: LW]
                                                              : w_rd_old[gl*LW +: LW];
        end
    endgenerate

    assign w_rd_word = (RDW_MODE != 0) ? w_rd_merged : w_rd_old;

    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] r_s1_data_q;
            logic          r_s1_vld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_vld_q <= 1'b0;
                    r_rvalid_q <= 1'b0;
                    r_dout_q   <= '0;
                end else begin
                    r_s1_vld_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_s1_data_q <= w_rd_word;
                    end
                    r_rvalid_q <= r_s1_vld_q;
                    if (r_s1_vld_q) begin
                        r_dout_q <= r_s1_data_q;
                    end
                end
            end
        end else begin : g_no_oreg
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rvalid_q <= 1'b0;
                    r_dout_q   <= '0;
                end else begin
                    r_rvalid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout_q <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign data_out = r_dout_q;
    assign rvalid   = r_rvalid_q;
    assign busy     = (r_state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_genram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : tb_genram_sdp
// Description : Bench for genram_sdp; two configurations (read-first/latency 1
//               and write-first/latency 2) driven from one directed sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_genram_sdp;

    logic        clk = 1'b0;
    logic        rst, we, re, clr;
    logic [3:0]  waddr, raddr;
    logic [11:0] wdata;
    logic [2:0]  wmask;
    logic [11:0] dout0, dout1;
    logic        rv0, rv1, busy0, busy1;

    always #5 clk = ~clk;

    genram_sdp #(.AW(4), .DW(12), .LW(4), .OREG(0), .RDW_MODE(0), .CLR_VAL(12'h000)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .data_out(dout0), .rvalid(rv0), .clr(clr), .busy(busy0)
    );

    genram_sdp #(.AW(4), .DW(12), .LW(4), .OREG(1), .RDW_MODE(1), .CLR_VAL(12'hFFF)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .data_out(dout1), .rvalid(rv1), .clr(clr), .busy(busy1)
    );

    typedef struct {
        logic [11:0] d;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [11:0] mem0 [16];
    logic [11:0] mem1 [16];
    logic        m_busy;
    logic [3:0]  m_cptr;
    logic [11:0] ed0, ed1;
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [11:0] merge(input logic [11:0] old, input logic [11:0] wd,
                                          input logic [2:0] wm);
        logic [11:0] r;
        r = old;
        for (int l = 0; l < 3; l++) begin
            if (wm[l]) r[l*4 +: 4] = wd[l*4 +: 4];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Reference behaviour applied to the inputs seen at the edge just taken.
    task automatic model(input logic r, input logic w, input logic [3:0] wa,
                         input logic [11:0] wd, input logic [2:0] wm,
                         input logic rr, input logic [3:0] ra, input logic c);
        logic [11:0] old1;
        logic        hit;
        if (r) begin
            m_busy = 1'b1;
            m_cptr = 4'd0;
            q0.delete();
            q1.delete();
            ed0 = 12'h000;
            ed1 = 12'h000;
        end else if (m_busy) begin
            mem0[m_cptr] = 12'h000;
            mem1[m_cptr] = 12'hFFF;
            if (m_cptr == 4'd15) m_busy = 1'b0;
            m_cptr = m_cptr + 4'd1;
        end else begin
            if (rr) begin
                old1 = mem1[ra];
                hit  = w && !c && (wa == ra);
                q0.push_back('{d: mem0[ra], due: cyc});
                q1.push_back('{d: hit ? merge(old1, wd, wm) : old1, due: cyc + 1});
            end
            if (w && !c) begin
                mem0[wa] = merge(mem0[wa], wd, wm);
                mem1[wa] = merge(mem1[wa], wd, wm);
            end
            if (c) begin
                m_busy = 1'b1;
                m_cptr = 4'd0;
            end
        end
    endtask

    task automatic check_outputs();
        logic e0, e1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e0  = 1'b1;
            ed0 = q0[0].d;
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e1  = 1'b1;
            ed1 = q1[0].d;
            void'(q1.pop_front());
        end
        chk("rvalid_oreg0",   {11'd0, rv0},   {11'd0, e0});
        chk("data_out_oreg0", dout0,          ed0);
        chk("busy_oreg0",     {11'd0, busy0}, {11'd0, m_busy});
        chk("rvalid_oreg1",   {11'd0, rv1},   {11'd0, e1});
        chk("data_out_oreg1", dout1,          ed1);
        chk("busy_oreg1",     {11'd0, busy1}, {11'd0, m_busy});
    endtask

    task automatic step(input logic r, input logic w, input logic [3:0] wa,
                        input logic [11:0] wd, input logic [2:0] wm,
                        input logic rr, input logic [3:0] ra, input logic c);
        rst = r; we = w; waddr = wa; wdata = wd; wmask = wm; re = rr; raddr = ra; clr = c;
        @(posedge clk);
        cyc++;
        model(r, w, wa, wd, wm, rr, ra, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d, input logic [2:0] m);
        step(1'b0, 1'b1, a, d, m, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 4'd0, 12'h000, 3'b000, 1'b1, a, 1'b0);
    endtask

    initial begin
        m_busy = 1'b1;
        m_cptr = 4'd0;
        ed0    = 12'h000;
        ed1    = 12'h000;

        // Reset, initial clear, then full read-back of the cleared array
        step(1'b1, 1'b0, 4'd0, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 12'h000, 3'b000, 1'b0, 4'd0, 1'b0);
        idle(17);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        // Full write, partial-lane write, empty-mask write
        wr(4'd3, 12'hABC, 3'b111);
        rd(4'd3);
        idle(2);
        wr(4'd3, 12'h123, 3'b010);
        rd(4'd3);
        wr(4'd3, 12'hFFF, 3'b000);
        rd(4'd3);
        idle(2);

        // Same-address read during write, with and without a partial mask
        wr(4'd5, 12'h111, 3'b111);
        step(1'b0, 1'b1, 4'd5, 12'h777, 3'b111, 1'b1, 4'd5, 1'b0);
        rd(4'd5);
        step(1'b0, 1'b1, 4'd5, 12'h9AB, 3'b101, 1'b1, 4'd5, 1'b0);
        rd(4'd5);
        idle(2);

        // Requested clear: concurrent write dropped, concurrent read served
        wr(4'd0, 12'h5A5, 3'b111);
        wr(4'd2, 12'h3C3, 3'b111);
        rd(4'd2);
        step(1'b0, 1'b1, 4'd2, 12'h999, 3'b111, 1'b1, 4'd3, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 4'd2, 12'h444, 3'b111, 1'b1, 4'(i), (i == 5));
        idle(1);
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        // Reset in the middle of a clear restarts it; writes during busy dropped
        wr(4'd2, 12'h0F0, 3'b111);
        wr(4'd9, 12'h0F0, 3'b111);
        step(1'b0, 1'b0, 4'd0, 12'h000, 3'b000, 1'b1, 4'd2, 1'b1);
        idle(7);
        step(1'b1, 1'b1, 4'd2, 12'h555, 3'b111, 1'b1, 4'd2, 1'b0);
        step(1'b1, 1'b1, 4'd2, 12'h555, 3'b111, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 4'd2, 12'h555, 3'b111, 1'b1, 4'd2, 1'b0);
        idle(1);
        rd(4'd2);
        rd(4'd9);
        idle(3);

        chk("reads_outstanding", 12'(q0.size() + q1.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/genram_sdp.md
Name: genram_sdp

Overview:
Parametrised simple-dual-port RAM, next generation of the team's generic RAM.
- One write port with per-lane write mask; one independent read port with a valid strobe.
- Selectable read-during-write semantics and optional output register.
- Built-in clear engine fills the whole array with a constant after reset or on request, so no consumer ever reads uninitialised contents.

Parameters:
AW, 9, address bits; depth NPOS = 2**AW
DW, 12, data word bits
LW, 4, write-lane width in bits; DW % LW == 0 required; NL = DW/LW lanes
OREG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
RDW_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new merged data)
CLR_VAL, 0, DW-bit word written to every location by the clear engine

Ports:
clk  in  1  global clock, rising edge
rst  in  1  synchronous reset, active-high
we  in  1  write request
waddr  in  AW  write address
wdata  in  DW  write data
wmask  in  NL  lane enables; bit i writes wdata[i*LW +: LW]
re  in  1  read request
raddr  in  AW  read address
data_out  out  DW  read data
rvalid  out  1  one-cycle strobe, data_out valid for an accepted read
clr  in  1  request full-array clear
busy  out  1  clear in progress; all accesses ignored

Behaviour:
- FSM states:
  - CLEAR: pointer cptr writes CLR_VAL to ram[cptr], one location per cycle.
  - READY: normal operation.
- rst=1 at an edge:
  - Enter CLEAR with cptr=0.
  - data_out=0, rvalid=0, busy=1, pipeline valid bits cleared.
  - Holds while rst is high; no array write while rst=1.
- First clear write happens at the first edge with rst=0.
- CLEAR: cptr increments each cycle. After ram[NPOS-1] is written, go to READY.
  - busy is high for exactly NPOS cycles after rst release.
- rst during CLEAR (any cptr) restarts at cptr=0; full NPOS cycles after release.
- During CLEAR: we and re are ignored.
  - No array change from the write port.
  - No rvalid.
  - clr is ignored (no restart).
- READY + clr=1: CLEAR begins at the next edge; busy=1 from that edge.
  - A we in the same cycle as clr is dropped.
  - A re in the same cycle as clr is accepted and completes normally.
  - Reads already in flight complete with rvalid.
- Write: we=1 in READY stores, at the edge, wdata lanes whose wmask bit is 1. Other lanes are unchanged. wmask=0 means no change.
- Read: re=1 in READY is accepted.
  - OREG=0: data_out updates and rvalid=1 in the cycle after the accepting edge.
  - OREG=1: one cycle later.
  - Back-to-back reads are fully pipelined: one per cycle.
  - rvalid is high exactly one cycle per accepted read.
- data_out holds its last value when no read completes. It is never cleared except by rst.
- Same-address we & re in one cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (new masked lanes, old other lanes).
  - The array is updated identically in both modes.
- Different addresses: fully independent; no hazard.
- Addresses wrap naturally at AW bits. No out-of-range case exists.

Test Plan:
1. AW=4, DW=12, LW=4, CLR_VAL=0. rst high 2 cycles then low -> busy=1 exactly 16 cycles. Then reads of addr 0..15 back-to-back -> 16 consecutive rvalid pulses, data_out=0x000 each.
2. Write addr 3 = 0xABC, wmask=3'b111, then re addr 3 -> data_out=0xABC with rvalid 1 cycle after accept (OREG=0), 2 cycles after (OREG=1).
3. Over 0xABC at addr 3, write 0x123 with wmask=3'b010 -> read returns 0xA2C; wmask=3'b000 write of 0xFFF -> still 0xA2C.
4. addr 5 holds 0x111; same cycle we addr 5 = 0x777 (mask 111) and re addr 5 -> RDW_MODE=0 returns 0x111, RDW_MODE=1 returns 0x777. Following read returns 0x777 in both modes.
5. CLR_VAL=0xFFF, after writes pulse clr with we addr 2 same cycle -> busy 16 cycles. re during busy gives no rvalid. Afterwards all 16 locations read 0xFFF, including addr 2.
6. Assert rst when cptr=7 -> after release busy lasts 16 more cycles. we addr 2 = 0x555 during busy is dropped; addr 2 reads CLR_VAL afterwards. data_out=0, rvalid=0 during rst.
